// File: rtl/gpu_insn_fetch.sv
// gpu_insn_fetch: PC owner and instruction fetch stage feeding decode through a two-entry queue
module gpu_insn_fetch #(
    parameter int ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH+1:0] RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       halt,
    input  logic                       redirect,
    input  logic [ADDRESS_WIDTH+1:0]   redirect_pc,
    output logic [ADDRESS_WIDTH-1:0]   ram_address,
    output logic                       ram_read,
    input  logic [31:0]                ram_read_data,
    output logic                       insn_valid,
    input  logic                       insn_ready,
    output logic [31:0]                insn,
    output logic [ADDRESS_WIDTH+1:0]   insn_pc,
    output logic                       fetching,
    output logic                       misaligned
);
    localparam int PW = ADDRESS_WIDTH + 2;
    localparam logic [PW-1:0] STEP = PW'(4);

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   pc, inflight_pc, q_pc0, q_pc1;
    logic [31:0]     q_insn0, q_insn1;
    logic [1:0]      count, fill;
    logic [2:0]      occupancy;
    logic            inflight, pop, push;

    assign insn_valid  = count != 2'd0;
    assign insn        = q_insn0;
    assign insn_pc     = q_pc0;
    assign ram_address = pc[PW-1:2];
    assign pop         = insn_valid && insn_ready;
    // a redirect kills the response arriving this cycle
    assign push        = inflight && !redirect;
    assign fill        = count - {1'b0, pop};
    // slots already promised: queued entries plus the read in flight, minus what leaves now
    assign occupancy   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next state: run starts fetching, halt parks it, run resumes once halt drops
    always_comb begin
        state_next = (state == IDLE)   ? (run ? FETCH : IDLE) :
                     (state == FETCH)  ? (halt ? HALTED : FETCH) :
                     (state == HALTED) ? ((run && !halt) ? FETCH : HALTED) : IDLE;
    end

    // outputs: issue only while there is guaranteed room for the response
    always_comb begin
        fetching = state == FETCH;
        ram_read = fetching && !halt && !redirect && occupancy < 3'd2;
    end

    // PC, in-flight tag and sticky misalignment flag
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            inflight   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            pc       <= redirect ? {redirect_pc[PW-1:2], 2'b00} : ram_read ? pc + STEP : pc;
            inflight <= ram_read;
            if (redirect && redirect_pc[1:0] != 2'b00)
                misaligned <= 1'b1;
        end
        if (ram_read)
            inflight_pc <= pc;
    end

    // two-entry output queue; head in slot 0, pop shifts slot 1 down
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                q_insn0 <= q_insn1;
                q_pc0   <= q_pc1;
            end
            if (push && fill == 2'd0) begin
                q_insn0 <= ram_read_data;
                q_pc0   <= inflight_pc;
            end
            if (push && fill != 2'd0) begin
                q_insn1 <= ram_read_data;
                q_pc1   <= inflight_pc;
            end
            count <= count - {1'b0, pop} + {1'b0, push};
        end
    end
endmodule

// File: tb/tb_gpu_insn_fetch.sv
// tb_gpu_insn_fetch: directed and random checks of the fetch stage against a scoreboard model
module tb_gpu_insn_fetch;
    localparam int AW = 16;
    localparam int PW = 18;

    logic            clock = 0, reset = 1, run = 0, halt = 0, redirect = 0, insn_ready = 0;
    logic [PW-1:0]   redirect_pc = '0;
    logic [AW-1:0]   ram_address;
    logic            ram_read, insn_valid, fetching, misaligned;
    logic [31:0]     ram_read_data, insn;
    logic [PW-1:0]   insn_pc;

    logic            run2 = 0, halt2 = 0, redirect2 = 0, ready2 = 1;
    logic [5:0]      redirect_pc2 = '0;
    logic [3:0]      ram_address2;
    logic            ram_read2, insn_valid2, fetching2, misaligned2;
    logic [31:0]     ram_read_data2, insn2;
    logic [5:0]      insn_pc2;

    logic [31:0]     mem [0:255];
    logic [31:0]     mem2 [0:15];
    logic [31:0]     prog [0:3];

    int total = 0, bad = 0, xfers = 0;

    gpu_insn_fetch #(.ADDRESS_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .run(run), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .ram_address(ram_address), .ram_read(ram_read),
        .ram_read_data(ram_read_data), .insn_valid(insn_valid), .insn_ready(insn_ready),
        .insn(insn), .insn_pc(insn_pc), .fetching(fetching), .misaligned(misaligned));

    gpu_insn_fetch #(.ADDRESS_WIDTH(4)) dut2 (
        .clock(clock), .reset(reset), .run(run2), .halt(halt2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .ram_address(ram_address2), .ram_read(ram_read2),
        .ram_read_data(ram_read_data2), .insn_valid(insn_valid2), .insn_ready(ready2),
        .insn(insn2), .insn_pc(insn_pc2), .fetching(fetching2), .misaligned(misaligned2));

    always #5 clock = ~clock;

    // one-cycle-latency instruction RAMs
    always @(posedge clock) begin
        if (ram_read) ram_read_data <= mem[ram_address[7:0]];
        if (ram_read2) ram_read_data2 <= mem2[ram_address2];
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: run/halt state, fetch PC, sticky flag and the queue of owed instructions
    int              st = 0;
    logic            mis_m = 0, xfer, exp_rd;
    logic [PW-1:0]   fpc = '0;
    logic [PW+31:0]  exp_q [$];
    logic [PW+31:0]  e;

    always @(negedge clock) begin
        xfer = insn_valid && insn_ready;
        if (reset) begin
            st = 0; mis_m = 0; fpc = '0; exp_q.delete();
        end else begin
            check("fetching", fetching, st == 1);
            check("misaligned", misaligned, mis_m);
            check("ram_address", ram_address, fpc >> 2);
            exp_rd = st == 1 && !halt && !redirect && (exp_q.size() - int'(xfer)) < 2;
            check("ram_read", ram_read, exp_rd);
            if (xfer) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    check("unexpected insn", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("insn_pc", insn_pc, e[PW+31:32]);
                    check("insn", insn, e[31:0]);
                end
            end
            if (redirect) begin
                exp_q.delete();
                fpc = {redirect_pc[PW-1:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) mis_m = 1;
            end else if (exp_rd) begin
                exp_q.push_back({fpc, mem[fpc[9:2]]});
                fpc = fpc + 4;
            end
            st = (st == 0) ? (run ? 1 : 0) : (st == 1) ? (halt ? 2 : 1) : ((run && !halt) ? 1 : 2);
        end
    end

    task automatic cyc(); @(posedge clock); #1; endtask
    task automatic smp(); @(negedge clock); endtask

    task automatic do_reset();
        reset = 1; run = 0; halt = 0; redirect = 0; insn_ready = 0; run2 = 0; redirect2 = 0;
        cyc();
        smp();
        check("rst valid", insn_valid, 0);
        check("rst read", ram_read, 0);
        check("rst fetching", fetching, 0);
        check("rst misaligned", misaligned, 0);
        check("rst pc", ram_address, 0);
        cyc();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int reads, x0, got;
        logic [5:0] pcs [$];
        logic [31:0] dat [$];
        prog[0] = 32'h00100093; prog[1] = 32'h00208113; prog[2] = 32'h00310193; prog[3] = 32'h00418213;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 16; i++) mem2[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];

        // back-to-back fetch
        do_reset();
        run = 1; insn_ready = 1;
        smp();
        check("t1 idle read", ram_read, 0);
        cyc();
        run = 0;
        for (int k = 1; k <= 6; k++) begin
            smp();
            if (k <= 2) begin
                check("t1 early read", ram_read, 1);
                check("t1 early valid", insn_valid, 0);
            end else begin
                check("t1 valid", insn_valid, 1);
                check("t1 pc", insn_pc, 4 * (k - 3));
                if (k - 3 < 4) check("t1 insn", insn, prog[k - 3]);
            end
            cyc();
        end

        // backpressure
        do_reset();
        run = 1;
        cyc();
        run = 0;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            smp();
            if (insn_valid) got = 1; else cyc();
        end
        check("t2 first valid", got, 1);
        reads = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            smp();
            reads += int'(ram_read);
        end
        check("t2 stalled reads", reads <= 2, 1);
        check("t2 full no read", ram_read, 0);
        check("t2 head pc", insn_pc, 0);
        cyc();
        insn_ready = 1;
        x0 = xfers;
        repeat (8) cyc();
        check("t2 throughput", xfers - x0, 8);

        // redirect flush
        do_reset();
        run = 1; insn_ready = 1;
        cyc();
        run = 0;
        repeat (3) cyc();
        insn_ready = 0; redirect = 1; redirect_pc = 18'h40;
        smp();
        check("t3 queued pc", insn_pc, 4);
        check("t3 redirect read", ram_read, 0);
        cyc();
        redirect = 0;
        smp();
        check("t3 flushed", insn_valid, 0);
        check("t3 resume read", ram_read, 1);
        check("t3 resume addr", ram_address, 16);
        cyc();
        smp();
        check("t3 flushed2", insn_valid, 0);
        cyc();
        insn_ready = 1;
        smp();
        check("t3 new valid", insn_valid, 1);
        check("t3 new pc", insn_pc, 18'h40);
        check("t3 new insn", insn, mem[16]);
        cyc();

        // halt and resume
        do_reset();
        run = 1; insn_ready = 1;
        cyc();
        run = 0;
        repeat (5) cyc();
        halt = 1;
        smp();
        check("t4 halt read", ram_read, 0);
        cyc();
        smp();
        check("t4 halted", fetching, 0);
        cyc();
        cyc();
        smp();
        check("t4 drained", insn_valid, 0);
        cyc();
        halt = 0; run = 1;
        smp();
        check("t4 still halted", ram_read, 0);
        cyc();
        run = 0;
        smp();
        check("t4 resumed", ram_read, 1);
        check("t4 resume addr", ram_address, 5);
        cyc();
        cyc();
        smp();
        check("t4 resume pc", insn_pc, 20);
        cyc();

        // reset with a full queue, then with a read in flight
        do_reset();
        run = 1;
        cyc();
        run = 0;
        repeat (3) cyc();
        smp();
        check("t6 full", insn_valid, 1);
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        smp();
        check("t6 valid", insn_valid, 0);
        check("t6 read", ram_read, 0);
        check("t6 fetching", fetching, 0);
        check("t6 pc", ram_address, 0);
        do_reset();
        run = 1; insn_ready = 1;
        cyc();
        run = 0;
        cyc();
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        smp();
        check("t6b valid", insn_valid, 0);
        cyc();
        smp();
        check("t6b killed", insn_valid, 0);
        cyc();

        // wrap and misalignment on the narrow instance
        do_reset();
        run2 = 1; redirect2 = 1; redirect_pc2 = 6'h3C;
        cyc();
        run2 = 0; redirect2 = 0;
        smp();
        check("t5 first read", ram_read2, 1);
        check("t5 first addr", ram_address2, 15);
        for (int n = 0; n < 10 && pcs.size() < 2; n++) begin
            smp();
            if (insn_valid2) begin
                pcs.push_back(insn_pc2);
                dat.push_back(insn2);
            end
            cyc();
        end
        check("t5 count", pcs.size(), 2);
        if (pcs.size() == 2) begin
            check("t5 pc0", pcs[0], 6'h3C);
            check("t5 pc1", pcs[1], 6'h00);
            check("t5 insn0", dat[0], mem2[15]);
            check("t5 insn1", dat[1], mem2[0]);
        end
        check("t5 aligned flag", misaligned2, 0);
        redirect2 = 1; redirect_pc2 = 6'h22;
        cyc();
        redirect2 = 0;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            smp();
            if (insn_valid2) got = 1; else cyc();
        end
        check("t5 mis valid", got, 1);
        check("t5 mis pc", insn_pc2, 6'h20);
        check("t5 mis insn", insn2, mem2[8]);
        check("t5 mis flag", misaligned2, 1);
        repeat (6) cyc();
        smp();
        check("t5 mis sticky", misaligned2, 1);
        cyc();
        do_reset();
        smp();
        check("t5 mis cleared", misaligned2, 0);
        cyc();

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc();
            run = $urandom_range(7) == 0;
            if ($urandom_range(15) == 0) halt = ~halt;
            redirect = $urandom_range(23) == 0;
            redirect_pc = PW'($urandom_range(1023));
            insn_ready = $urandom_range(3) != 0;
            reset = $urandom_range(699) == 0;
        end
        cyc();
        reset = 0; run = 0; halt = 0; redirect = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
